snake_score_display: RTL and testbench

//  Parametrised successor to the 4-bit score counter + single-digit 7-seg path.

---
 rtl/snake_score_display.sv | 141 ++++++++++++++
 tb/tb_snake_score_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/snake_score_display.sv
`default_nettype none
// ============================================================================
// Module  : snake_score_display
// Purpose : N-digit BCD score/high score with win flag and multiplexed,
//           leading-zero-blanked 7-segment display.
// Rev     : 1.0  initial release
// ============================================================================
module snake_score_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_MAX  = 99999,
    parameter int TARGET_SCORE = 20
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CLEAR_IN,
    input  logic                    INC_IN,
    input  logic                    SHOW_HIGH_IN,
    output logic [4*NUM_DIGITS-1:0] SCORE_BCD_OUT,
    output logic [4*NUM_DIGITS-1:0] HIGH_BCD_OUT,
    output logic                    WIN_OUT,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);
    localparam int c_SW    = 4 * NUM_DIGITS;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_W = (REFRESH_MAX > 0) ? $clog2(REFRESH_MAX + 1) : 1;

    logic [c_SW-1:0]    r_score, r_high, w_score_inc, w_sel_bcd;
    logic [31:0]        r_shadow, w_shadow_next;
    logic               r_win, r_inc_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [NUM_DIGITS-1:0] r_seg;
    logic [7:0]         r_hex, w_hex;
    logic [6:0]         w_seg7;
    logic [3:0]         w_digit;
    logic               w_event, w_carry, w_do_inc, w_upper_zero, w_blank;

    // Ripple BCD increment; a carry out of the top digit means all nines.
    always_comb begin
        w_score_inc = r_score;
        w_carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    assign w_event       = INC_IN & ~r_inc_q;
    assign w_do_inc      = w_event & ~w_carry;
    assign w_shadow_next = CLEAR_IN ? 32'd0 : (w_do_inc ? r_shadow + 32'd1 : r_shadow);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_score  <= '0;
            r_high   <= '0;
            r_shadow <= '0;
            r_win    <= 1'b0;
            r_inc_q  <= 1'b0;
        end else begin
            r_inc_q  <= INC_IN;
            r_shadow <= w_shadow_next;
            r_win    <= (w_shadow_next >= 32'(TARGET_SCORE));
            if (CLEAR_IN) begin
                r_score <= '0;
                // BCD ordering matches binary ordering, so compare directly.
                if (r_score > r_high)
                    r_high <= r_score;
            end else if (w_do_inc) begin
                r_score <= w_score_inc;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_CNT_W'(REFRESH_MAX)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_sel_bcd = SHOW_HIGH_IN ? r_high : r_score;
    assign w_digit   = w_sel_bcd[4*r_idx +: 4];

    // Blank a non-zero position when it and every more significant digit is 0.
    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((c_IDX_W'(i) >= r_idx) && (w_sel_bcd[4*i +: 4] != 4'd0))
                w_upper_zero = 1'b0;
        end
    end
    assign w_blank = (r_idx != '0) && w_upper_zero;

    always_comb begin
        case (w_digit)
            4'd0:    w_seg7 = 7'h40;
            4'd1:    w_seg7 = 7'h79;
            4'd2:    w_seg7 = 7'h24;
            4'd3:    w_seg7 = 7'h30;
            4'd4:    w_seg7 = 7'h19;
            4'd5:    w_seg7 = 7'h12;
            4'd6:    w_seg7 = 7'h02;
            4'd7:    w_seg7 = 7'h78;
            4'd8:    w_seg7 = 7'h00;
            4'd9:    w_seg7 = 7'h10;
            default: w_seg7 = 7'h7F;
        endcase
    end

    assign w_hex = (w_blank || (w_digit > 4'd9)) ? 8'hFF
                 : {~(SHOW_HIGH_IN && (r_idx == '0)), w_seg7};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_seg <= '1;
            r_hex <= 8'hFF;
        end else begin
            r_seg <= ~(NUM_DIGITS'(1) << r_idx);
            r_hex <= w_hex;
        end
    end

    assign SCORE_BCD_OUT  = r_score;
    assign HIGH_BCD_OUT   = r_high;
    assign WIN_OUT        = r_win;
    assign SEG_SELECT_OUT = r_seg;
    assign HEX_OUT        = r_hex;
endmodule
`default_nettype wire

// File: tb/tb_snake_score_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_snake_score_display
// Purpose : Directed self-checking bench for snake_score_display (4 digits).
// Rev     : 1.0  initial release
// ============================================================================
module tb_snake_score_display;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CLEAR_IN = 1'b0;
    logic        INC_IN = 1'b0;
    logic        SHOW_HIGH_IN = 1'b0;
    logic [15:0] SCORE_BCD_OUT, HIGH_BCD_OUT;
    logic        WIN_OUT;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;

    int errors = 0;
    int checks = 0;

    snake_score_display #(.NUM_DIGITS(4), .REFRESH_MAX(3), .TARGET_SCORE(20)) dut (
        .CLK(CLK), .RESET(RESET), .CLEAR_IN(CLEAR_IN), .INC_IN(INC_IN),
        .SHOW_HIGH_IN(SHOW_HIGH_IN), .SCORE_BCD_OUT(SCORE_BCD_OUT),
        .HIGH_BCD_OUT(HIGH_BCD_OUT), .WIN_OUT(WIN_OUT),
        .SEG_SELECT_OUT(SEG_SELECT_OUT), .HEX_OUT(HEX_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input string tag, input logic [3:0] sel);
        int n = 0;
        while (SEG_SELECT_OUT !== sel && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {28'd0, SEG_SELECT_OUT}, {28'd0, sel});
    endtask

    task automatic pulse();
        INC_IN = 1'b1;
        @(negedge CLK);
        INC_IN = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int n;
        #12;
        check("rst_sel",   {28'd0, SEG_SELECT_OUT}, 32'hF);
        check("rst_hex",   {24'd0, HEX_OUT}, 32'hFF);
        check("rst_score", {16'd0, SCORE_BCD_OUT}, 32'h0);
        check("rst_high",  {16'd0, HIGH_BCD_OUT}, 32'h0);
        check("rst_win",   {31'd0, WIN_OUT}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // Scan order and blanking with score 0
        wait_sel("scan_e", 4'hE);
        check("scan_d0_hex", {24'd0, HEX_OUT}, 32'hC0);
        wait_sel("scan_d", 4'hD);
        check("scan_d1_hex", {24'd0, HEX_OUT}, 32'hFF);
        n = 0;
        while (SEG_SELECT_OUT === 4'hD && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("scan_dwell", n, 32'd4);
        check("scan_b", {28'd0, SEG_SELECT_OUT}, 32'hB);
        check("scan_d2_hex", {24'd0, HEX_OUT}, 32'hFF);
        wait_sel("scan_7", 4'h7);
        check("scan_d3_hex", {24'd0, HEX_OUT}, 32'hFF);

        // Held increment counts once, with one-cycle latency
        @(negedge CLK);
        INC_IN = 1'b1;
        @(negedge CLK);
        check("inc_latency", {16'd0, SCORE_BCD_OUT}, 32'h1);
        repeat (9) @(negedge CLK);
        check("hold_once", {16'd0, SCORE_BCD_OUT}, 32'h1);
        INC_IN = 1'b0;
        @(negedge CLK);
        repeat (9) pulse();
        check("bcd_carry", {16'd0, SCORE_BCD_OUT}, 32'h10);
        wait_sel("ten_d", 4'hD);
        check("ten_d1_hex", {24'd0, HEX_OUT}, 32'hF9);
        wait_sel("ten_b", 4'hB);
        check("ten_d2_hex", {24'd0, HEX_OUT}, 32'hFF);
        wait_sel("ten_e", 4'hE);
        check("ten_d0_hex", {24'd0, HEX_OUT}, 32'hC0);

        // Win threshold and clear into high score
        repeat (9) pulse();
        check("score19", {16'd0, SCORE_BCD_OUT}, 32'h19);
        check("win19", {31'd0, WIN_OUT}, 32'h0);
        INC_IN = 1'b1;
        @(negedge CLK);
        check("score20", {16'd0, SCORE_BCD_OUT}, 32'h20);
        check("win20", {31'd0, WIN_OUT}, 32'h1);
        INC_IN = 1'b0;
        @(negedge CLK);
        CLEAR_IN = 1'b1;
        @(negedge CLK);
        CLEAR_IN = 1'b0;
        check("clr_score", {16'd0, SCORE_BCD_OUT}, 32'h0);
        check("clr_win", {31'd0, WIN_OUT}, 32'h0);
        check("clr_high", {16'd0, HIGH_BCD_OUT}, 32'h20);

        // Clear beats a simultaneous increment; lower score leaves high alone
        repeat (3) pulse();
        check("score3", {16'd0, SCORE_BCD_OUT}, 32'h3);
        CLEAR_IN = 1'b1;
        INC_IN = 1'b1;
        @(negedge CLK);
        CLEAR_IN = 1'b0;
        check("clr_wins", {16'd0, SCORE_BCD_OUT}, 32'h0);
        @(negedge CLK);
        check("clr_no_late_inc", {16'd0, SCORE_BCD_OUT}, 32'h0);
        INC_IN = 1'b0;
        @(negedge CLK);
        repeat (5) pulse();
        check("score5", {16'd0, SCORE_BCD_OUT}, 32'h5);
        CLEAR_IN = 1'b1;
        @(negedge CLK);
        CLEAR_IN = 1'b0;
        check("high_kept", {16'd0, HIGH_BCD_OUT}, 32'h20);

        // High-score display with decimal point on digit 0
        SHOW_HIGH_IN = 1'b1;
        wait_sel("hi_e", 4'hE);
        @(negedge CLK);
        check("hi_d0_hex", {24'd0, HEX_OUT}, 32'h40);
        wait_sel("hi_d", 4'hD);
        @(negedge CLK);
        check("hi_d1_hex", {24'd0, HEX_OUT}, 32'hA4);
        wait_sel("hi_b", 4'hB);
        check("hi_d2_hex", {24'd0, HEX_OUT}, 32'hFF);
        SHOW_HIGH_IN = 1'b0;

        // Saturation at all nines
        repeat (9999) pulse();
        check("score9999", {16'd0, SCORE_BCD_OUT}, 32'h9999);
        check("win9999", {31'd0, WIN_OUT}, 32'h1);
        pulse();
        check("sat_score", {16'd0, SCORE_BCD_OUT}, 32'h9999);
        check("sat_win", {31'd0, WIN_OUT}, 32'h1);
        CLEAR_IN = 1'b1;
        @(negedge CLK);
        CLEAR_IN = 1'b0;
        check("high9999", {16'd0, HIGH_BCD_OUT}, 32'h9999);

        SHOW_HIGH_IN = 1'b1;
        wait_sel("h9_7", 4'h7);
        @(negedge CLK);
        check("h9_d3_hex", {24'd0, HEX_OUT}, 32'h90);
        wait_sel("h9_e", 4'hE);
        @(negedge CLK);
        check("h9_d0_hex", {24'd0, HEX_OUT}, 32'h10);

        // Asynchronous reset mid-scan
        #2;
        RESET = 1'b1;
        #1;
        check("amid_sel", {28'd0, SEG_SELECT_OUT}, 32'hF);
        check("amid_hex", {24'd0, HEX_OUT}, 32'hFF);
        check("amid_high", {16'd0, HIGH_BCD_OUT}, 32'h0);
        check("amid_score", {16'd0, SCORE_BCD_OUT}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("restart_sel", {28'd0, SEG_SELECT_OUT}, 32'hE);
        check("restart_hex", {24'd0, HEX_OUT}, 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
